// File: rtl/seq_multiplier_pkg.sv
// Shared ALU definitions for the sequential multiplier: state encoding and default width.
// No timing or flow control of its own.
package seq_multiplier_pkg;

   localparam int DEF_WIDTH = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_multiplier_mul_step.sv
// One shift-and-add iteration: conditional (WIDTH+1)-bit add of mcand into acc_hi, then right shift.
// Purely combinational; no backpressure.
module seq_multiplier_mul_step
   import seq_multiplier_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] acc_hi,
   input  logic [WIDTH-1:0] acc_lo,
   input  logic [WIDTH-1:0] mcand,
   output logic [WIDTH-1:0] next_hi,
   output logic [WIDTH-1:0] next_lo
);

   localparam int NS = (WIDTH + 3) / 4;

   logic [WIDTH-1:0] addend;
   logic [WIDTH:0]   sum;
   logic             rc;

   // Ripple through 4-bit slices; each slice's carry-out feeds the next slice's carry-in.
   always_comb begin
      addend = acc_lo[0] ? mcand : '0;
      sum    = '0;
      rc     = 1'b0;
      for (int s = 0; s < NS; s++) begin
         for (int k = 0; k < 4; k++) begin
            if (4 * s + k < WIDTH) begin
               sum[4*s+k] = acc_hi[4*s+k] ^ addend[4*s+k] ^ rc;
               rc = (acc_hi[4*s+k] & addend[4*s+k]) | (rc & (acc_hi[4*s+k] ^ addend[4*s+k]));
            end
         end
      end
      sum[WIDTH] = rc;
   end

   // After the shift the add's carry-out lands in the msb of next_hi, so the
   // accumulator's upper bit is always zero and need not be stored.
   assign next_hi = sum[WIDTH:1];
   assign next_lo = {sum[0], acc_lo[WIDTH-1:1]};

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned shift-and-add multiplier: one step per clock, done pulses WIDTH edges after an accepted start.
// start is only honoured while busy=0 (IDLE or DONE); a start during RUN is dropped.
module seq_multiplier
   import seq_multiplier_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int              CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH-1:0] next_hi;
   logic [WIDTH-1:0] next_lo;

   seq_multiplier_mul_step #(.WIDTH(WIDTH)) u_step (
      .acc_hi  (acc_hi),
      .acc_lo  (acc_lo),
      .mcand   (mcand),
      .next_hi (next_hi),
      .next_lo (next_lo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         count   <= '0;
         mcand   <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               done <= 1'b0;
               if (start) begin
                  mcand  <= a;
                  acc_hi <= '0;
                  acc_lo <= b;
                  count  <= '0;
                  busy   <= 1'b1;
                  state  <= S_RUN;
               end else begin
                  state  <= S_IDLE;
               end
            end
            S_RUN: begin
               acc_hi <= next_hi;
               acc_lo <= next_lo;
               // count holds at LAST on the final step so it never wraps.
               if (count == LAST) begin
                  product <= {next_hi, next_lo};
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  count   <= count + CW'(1);
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
